writeback_stage: RTL

WRITEBACK_STAGE -- requirements
Module: writeback_stage

---
 rtl/writeback_stage.sv | 106 ++++++++++
 1 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: selects the writeback source, writes the 8x16 register
// file, derives the {N,Z,P} condition codes and provides two registered
// read ports with optional same-cycle write forwarding.
module writeback_stage #(
    // 1: a read of the register being written returns the new data at the
    //    same edge; 0: it returns the old contents, the new value follows.
    parameter bit BYPASS = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [1:0]  W_Control,
    input  logic [15:0] aluout,
    input  logic [15:0] pcout,
    input  logic [15:0] npc,
    input  logic [15:0] memout,
    input  logic        enable_writeback,
    input  logic [2:0]  sr1,
    input  logic [2:0]  sr2,
    input  logic [2:0]  dr,
    output logic [15:0] d1,
    output logic [15:0] d2,
    output logic [2:0]  psr
);

    localparam logic [1:0] SRC_ALU = 2'b00;
    localparam logic [1:0] SRC_MEM = 2'b01;
    localparam logic [1:0] SRC_PC  = 2'b10;
    localparam logic [1:0] SRC_NPC = 2'b11;

    localparam logic [2:0] CC_NEG  = 3'b100;
    localparam logic [2:0] CC_ZERO = 3'b010;
    localparam logic [2:0] CC_POS  = 3'b001;

    logic [15:0] dr_in;

    logic [15:0] rf_q [8];
    logic [15:0] rf_d [8];
    logic [15:0] d1_q, d1_d;
    logic [15:0] d2_q, d2_d;
    logic [2:0]  psr_q, psr_d;

    // Writeback source select; every encoding maps to a source.
    always_comb begin
        dr_in = aluout;
        case (W_Control)
            SRC_ALU: dr_in = aluout;
            SRC_MEM: dr_in = memout;
            SRC_PC:  dr_in = pcout;
            SRC_NPC: dr_in = npc;
            default: dr_in = aluout;
        endcase
    end

    // Next register-file contents and condition codes; both hold unless enabled.
    always_comb begin
        for (int i = 0; i < 8; i++) begin
            rf_d[i] = rf_q[i];
        end
        psr_d = psr_q;
        if (enable_writeback) begin
            rf_d[dr] = dr_in;
            if (dr_in[15]) begin
                psr_d = CC_NEG;
            end else if (dr_in == 16'h0000) begin
                psr_d = CC_ZERO;
            end else begin
                psr_d = CC_POS;
            end
        end
    end

    // Read ports: with forwarding the post-write view (rf_d) is read, which
    // already carries dr_in at index dr; otherwise the pre-write view.
    always_comb begin
        d1_d = rf_q[sr1];
        d2_d = rf_q[sr2];
        if (BYPASS) begin
            d1_d = rf_d[sr1];
            d2_d = rf_d[sr2];
        end
    end

    // State update; reset clears everything immediately and blocks any write.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= 16'h0000;
            end
            d1_q  <= 16'h0000;
            d2_q  <= 16'h0000;
            psr_q <= 3'b000;
        end else begin
            for (int i = 0; i < 8; i++) begin
                rf_q[i] <= rf_d[i];
            end
            d1_q  <= d1_d;
            d2_q  <= d2_d;
            psr_q <= psr_d;
        end
    end

    assign d1  = d1_q;
    assign d2  = d2_q;
    assign psr = psr_q;

endmodule
